// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encoding,
// default register-index width and the per-cycle pipeline control bundle.
package hazard_pkg;

  localparam int REG_AW_DEFAULT = 5;

  typedef enum logic {
    S_RUN     = 1'b0,
    S_MC_WAIT = 1'b1
  } state_t;

  // One cycle's worth of pipeline register controls.
  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_bubble;
    logic id_ex_hold;
    logic ex_mem_bubble;
  } ctrl_t;

  // Control-zero pattern: every control deasserted.
  localparam ctrl_t NOP_CTRL = '0;

endpackage : hazard_pkg

// File: rtl/pipeline_hazard_control.sv
// Hazard sequencing for the 5-stage pipeline: freezes EX for the multi-cycle
// unit, stalls ID for hazards the forwarding network cannot cover, and
// flushes IF/ID on a taken branch resolved in ID.
// Optional feature macro: HAZARD_STATS_EN adds stall/flush/freeze counters.
module pipeline_hazard_control
  import hazard_pkg::*;
#(
  parameter int REG_AW     = REG_AW_DEFAULT,
  parameter int MC_LATENCY = 4
`ifdef HAZARD_STATS_EN
  ,
  parameter int CNT_W      = 16
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] if_id_register_rs,
  input  logic [REG_AW-1:0] if_id_registerrt,
  input  logic              if_id_uses_rt,
  input  logic              id_is_branch,
  input  logic              branch_taken,
  input  logic [REG_AW-1:0] id_ex_register_rd,
  input  logic              id_ex_regwrite,
  input  logic              id_ex_memread,
  input  logic              id_ex_mc_op,
  input  logic [REG_AW-1:0] ex_mem_register_rd,
  input  logic              ex_mem_memread,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              if_id_flush,
  output logic              id_ex_bubble,
  output logic              id_ex_hold,
  output logic              ex_mem_bubble,
  output logic              busy
`ifdef HAZARD_STATS_EN
  ,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_count,
  output logic [CNT_W-1:0]  mc_cycles
`endif
);

  localparam int MC_CW   = $clog2(MC_LATENCY) + 1;
  localparam int MC_LOAD_INT = (MC_LATENCY > 1) ? (MC_LATENCY - 2) : 0;
  localparam logic [MC_CW-1:0] MC_LOAD = MC_LOAD_INT[MC_CW-1:0];

  state_t           state;
  logic [MC_CW-1:0] mc_cnt;
  // High for the single cycle after a wait ends: the multi-cycle op is still
  // in EX (it was held) and must leave without starting a second freeze.
  logic             mc_release;

  logic  mc_start;
  logic  freeze;
  logic  stall_raw;
  logic  stall;
  logic  flush;
  ctrl_t ctrl;

  // rd != 0 and rd matches a source register the ID instruction actually reads.
  function automatic logic dep(input logic [REG_AW-1:0] rd,
                               input logic [REG_AW-1:0] rs,
                               input logic [REG_AW-1:0] rt,
                               input logic              uses_rt);
    return (rd != '0) && ((rd == rs) || (uses_rt && (rd == rt)));
  endfunction

  // Hazard detection and priority resolution: freeze > ID stall > flush.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    mc_start  = (MC_LATENCY > 1) && (state == S_RUN) && id_ex_mc_op && !mc_release;
    freeze    = (state == S_MC_WAIT) || mc_start;
    stall_raw = (id_ex_memread &&
                 dep(id_ex_register_rd, if_id_register_rs, if_id_registerrt, if_id_uses_rt))
             || (id_is_branch && id_ex_regwrite &&
                 dep(id_ex_register_rd, if_id_register_rs, if_id_registerrt, if_id_uses_rt))
             || (id_is_branch && ex_mem_memread &&
                 dep(ex_mem_register_rd, if_id_register_rs, if_id_registerrt, if_id_uses_rt));
    stall     = stall_raw && !freeze;
    flush     = id_is_branch && branch_taken && !stall_raw && !freeze;

    ctrl             = NOP_CTRL;
    ctrl.pc_write    = 1'b1;
    ctrl.if_id_write = 1'b1;
    if (freeze) begin
      ctrl.pc_write      = 1'b0;
      ctrl.if_id_write   = 1'b0;
      ctrl.id_ex_hold    = 1'b1;
      ctrl.ex_mem_bubble = 1'b1;
    end else if (stall) begin
      ctrl.pc_write     = 1'b0;
      ctrl.if_id_write  = 1'b0;
      ctrl.id_ex_bubble = 1'b1;
    end else if (flush) begin
      ctrl.if_id_flush = 1'b1;
    end
  end

  assign pc_write      = ctrl.pc_write;
  assign if_id_write   = ctrl.if_id_write;
  assign if_id_flush   = ctrl.if_id_flush;
  assign id_ex_bubble  = ctrl.id_ex_bubble;
  assign id_ex_hold    = ctrl.id_ex_hold;
  assign ex_mem_bubble = ctrl.ex_mem_bubble;
  assign busy          = (state != S_RUN);

  // Multi-cycle wait FSM: counts down the remaining frozen cycles of an EX op.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      state      <= S_RUN;
      mc_cnt     <= '0;
      mc_release <= 1'b0;
    end else begin
      case (state)
        S_RUN: begin
          mc_release <= 1'b0;
          if (mc_start) begin
            state  <= S_MC_WAIT;
            mc_cnt <= MC_LOAD;
          end
        end
        S_MC_WAIT: begin
          if (mc_cnt == '0) begin
            state      <= S_RUN;
            mc_release <= 1'b1;
          end else begin
            mc_cnt <= mc_cnt - 1'b1;
          end
        end
        default: begin
          state      <= S_RUN;
          mc_cnt     <= '0;
          mc_release <= 1'b0;
        end
      endcase
    end
  end

`ifdef HAZARD_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Saturating event counters for stall, flush and freeze cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      flush_count  <= '0;
      mc_cycles    <= '0;
    end else begin
      if (stall && (stall_cycles != CNT_MAX)) stall_cycles <= stall_cycles + 1'b1;
      if (flush && (flush_count  != CNT_MAX)) flush_count  <= flush_count + 1'b1;
      if (freeze && (mc_cycles   != CNT_MAX)) mc_cycles    <= mc_cycles + 1'b1;
    end
  end
`endif

endmodule : pipeline_hazard_control

// File: tb/tb_pipeline_hazard_control.sv
// Self-checking bench for pipeline_hazard_control: directed scenarios with
// hand-derived expectations, then random stimulus against a behavioural model.
module tb_pipeline_hazard_control;

  localparam int AW  = 5;
  localparam int LAT = 4;

  // Output vector order: {pc_write, if_id_write, if_id_flush, id_ex_bubble, id_ex_hold, ex_mem_bubble, busy}
  localparam logic [6:0] V_RUN    = 7'b1100000;
  localparam logic [6:0] V_STALL  = 7'b0001000;
  localparam logic [6:0] V_FLUSH  = 7'b1110000;
  localparam logic [6:0] V_FRZ    = 7'b0000110;
  localparam logic [6:0] V_FRZ_B  = 7'b0000111;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] if_id_register_rs, if_id_registerrt, id_ex_register_rd, ex_mem_register_rd;
  logic          if_id_uses_rt, id_is_branch, branch_taken;
  logic          id_ex_regwrite, id_ex_memread, id_ex_mc_op, ex_mem_memread;
  logic          pc_write, if_id_write, if_id_flush, id_ex_bubble, id_ex_hold, ex_mem_bubble, busy;
`ifdef HAZARD_STATS_EN
  logic [15:0]   stall_cycles, flush_count, mc_cycles;
`endif

  int checks = 0;
  int fails  = 0;

  // Model state: remaining cycles of the wait phase and the post-wait release cycle.
  int wait_left = 0;
  bit released  = 1'b0;
  int m_stall = 0, m_flush = 0, m_mc = 0;

  pipeline_hazard_control #(.REG_AW(AW), .MC_LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_id_register_rs(if_id_register_rs), .if_id_registerrt(if_id_registerrt),
    .if_id_uses_rt(if_id_uses_rt), .id_is_branch(id_is_branch), .branch_taken(branch_taken),
    .id_ex_register_rd(id_ex_register_rd), .id_ex_regwrite(id_ex_regwrite),
    .id_ex_memread(id_ex_memread), .id_ex_mc_op(id_ex_mc_op),
    .ex_mem_register_rd(ex_mem_register_rd), .ex_mem_memread(ex_mem_memread),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .id_ex_hold(id_ex_hold), .ex_mem_bubble(ex_mem_bubble),
    .busy(busy)
`ifdef HAZARD_STATS_EN
    , .stall_cycles(stall_cycles), .flush_count(flush_count), .mc_cycles(mc_cycles)
`endif
  );

  initial forever #5 clk = ~clk;

  function automatic bit reads(input int rd);
    return rd != 0 && (rd == int'(if_id_register_rs) ||
                       (if_id_uses_rt && rd == int'(if_id_registerrt)));
  endfunction

  task automatic clear_inputs();
    if_id_register_rs = '0; if_id_registerrt = '0; if_id_uses_rt = 0;
    id_is_branch = 0; branch_taken = 0;
    id_ex_register_rd = '0; id_ex_regwrite = 0; id_ex_memread = 0; id_ex_mc_op = 0;
    ex_mem_register_rd = '0; ex_mem_memread = 0;
  endtask

  // One pipeline cycle: compare at the falling edge, then advance the model at the rising edge.
  task automatic tick(input string tag, input bit use_hand, input logic [6:0] hand);
    bit frz, haz, stl, fl, start;
    logic [6:0] mexp, obs, exp_v;
    @(negedge clk);
    start = (LAT > 1) && wait_left == 0 && id_ex_mc_op && !released;
    frz   = (wait_left > 0) || start;
    haz   = (id_ex_memread && reads(int'(id_ex_register_rd))) ||
            (id_is_branch && id_ex_regwrite && reads(int'(id_ex_register_rd))) ||
            (id_is_branch && ex_mem_memread && reads(int'(ex_mem_register_rd)));
    stl   = haz && !frz;
    fl    = id_is_branch && branch_taken && !haz && !frz;
    if (frz)       mexp = (wait_left > 0) ? V_FRZ_B : V_FRZ;
    else if (stl)  mexp = V_STALL;
    else if (fl)   mexp = V_FLUSH;
    else           mexp = V_RUN;
    exp_v = use_hand ? hand : mexp;
    obs   = {pc_write, if_id_write, if_id_flush, id_ex_bubble, id_ex_hold, ex_mem_bubble, busy};
    checks++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
    end
`ifdef HAZARD_STATS_EN
    checks++;
    assert ({stall_cycles, flush_count, mc_cycles} === {16'(m_stall), 16'(m_flush), 16'(m_mc)}) else begin
      fails++;
      $error("FAIL %s_stats observed=%0d/%0d/%0d expected=%0d/%0d/%0d", tag,
             stall_cycles, flush_count, mc_cycles, m_stall, m_flush, m_mc);
    end
`endif
    @(posedge clk);
    if (!rst_n) begin
      wait_left = 0; released = 0; m_stall = 0; m_flush = 0; m_mc = 0;
    end else begin
      if (stl && m_stall < 65535) m_stall++;
      if (fl && m_flush < 65535)  m_flush++;
      if (frz && m_mc < 65535)    m_mc++;
      if (wait_left > 0) begin
        wait_left--;
        released = (wait_left == 0);
      end else begin
        released = 0;
        if (start) wait_left = LAT - 1;
      end
    end
    #1;
  endtask

  initial begin
    clear_inputs();
    rst_n = 0;
    #1;
    tick("reset", 1, V_RUN);
    rst_n = 1;
    tick("post_reset", 1, V_RUN);

    // 1: load-use, one stall cycle then clear.
    id_ex_register_rd = 5'd2; id_ex_memread = 1; id_ex_regwrite = 1;
    if_id_register_rs = 5'd2; if_id_registerrt = 5'd4; if_id_uses_rt = 1;
    tick("t1_loaduse", 1, V_STALL);
    id_ex_register_rd = '0; id_ex_memread = 0; id_ex_regwrite = 0;
    ex_mem_register_rd = 5'd2; ex_mem_memread = 1;
    tick("t1_clear", 1, V_RUN);
    clear_inputs();

    // 2: branch on a load, stalls via (b) then (c).
    id_ex_register_rd = 5'd5; id_ex_memread = 1; id_ex_regwrite = 1;
    if_id_register_rs = 5'd5; if_id_registerrt = 5'd6; if_id_uses_rt = 1; id_is_branch = 1;
    tick("t2_stall_b", 1, V_STALL);
    id_ex_register_rd = '0; id_ex_memread = 0; id_ex_regwrite = 0;
    ex_mem_register_rd = 5'd5; ex_mem_memread = 1;
    tick("t2_stall_c", 1, V_STALL);
    ex_mem_register_rd = '0; ex_mem_memread = 0;
    tick("t2_clear", 1, V_RUN);
    clear_inputs();

    // 3: multi-cycle op: freeze entry, three wait cycles, then release.
    id_ex_mc_op = 1;
    tick("t3_freeze", 1, V_FRZ);
    tick("t3_wait0", 1, V_FRZ_B);
    tick("t3_wait1", 1, V_FRZ_B);
    tick("t3_wait2", 1, V_FRZ_B);
    tick("t3_release", 1, V_RUN);
    id_ex_mc_op = 0;
    tick("t3_after", 1, V_RUN);

    // 4: taken branch flush, then the same branch behind an ALU dependency.
    id_is_branch = 1; branch_taken = 1; if_id_register_rs = 5'd7; if_id_registerrt = 5'd8; if_id_uses_rt = 1;
    tick("t4_flush", 1, V_FLUSH);
    id_ex_register_rd = 5'd7; id_ex_regwrite = 1;
    tick("t4_dep_stall", 1, V_STALL);
    id_ex_register_rd = '0; id_ex_regwrite = 0;
    tick("t4_late_flush", 1, V_FLUSH);
    clear_inputs();

    // 5: freeze masks a simultaneous load-use; the stall shows once EX releases.
    id_ex_mc_op = 1; id_ex_memread = 1; id_ex_regwrite = 1; id_ex_register_rd = 5'd3;
    if_id_register_rs = 5'd3;
    tick("t5_freeze", 1, V_FRZ);
    tick("t5_wait0", 1, V_FRZ_B);
    tick("t5_wait1", 1, V_FRZ_B);
    tick("t5_wait2", 1, V_FRZ_B);
    tick("t5_loaduse", 1, V_STALL);
    clear_inputs();
    tick("t5_clear", 1, V_RUN);

    // 6: reset during the second wait cycle aborts the wait.
    id_ex_mc_op = 1;
    tick("t6_freeze", 1, V_FRZ);
    tick("t6_wait0", 1, V_FRZ_B);
    rst_n = 0;
    tick("t6_wait1_rst", 1, V_FRZ_B);
    rst_n = 1; id_ex_mc_op = 0;
    tick("t6_run", 1, V_RUN);

    // Random phase against the model; small register range makes dependencies common.
    for (int i = 0; i < 300; i++) begin
      rst_n              = ($urandom_range(0, 39) != 0);
      if_id_register_rs  = AW'($urandom_range(0, 3));
      if_id_registerrt   = AW'($urandom_range(0, 3));
      if_id_uses_rt      = 1'($urandom);
      id_is_branch       = 1'($urandom);
      branch_taken       = 1'($urandom);
      id_ex_register_rd  = AW'($urandom_range(0, 3));
      id_ex_regwrite     = 1'($urandom);
      id_ex_memread      = 1'($urandom);
      id_ex_mc_op        = ($urandom_range(0, 5) == 0);
      ex_mem_register_rd = AW'($urandom_range(0, 3));
      ex_mem_memread     = 1'($urandom);
      tick($sformatf("rand%0d", i), 0, V_RUN);
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule : tb_pipeline_hazard_control
